// File: rtl/health_test_ctrl.sv
// Entropy-source health-test controller: runs the repetition count and adaptive proportion
// tests on every accepted noise sample, gates forwarding until startup passes, latches alarms.
module health_test_ctrl #(
    parameter int SAMPLE_W   = 8,
    parameter int RCT_CUTOFF = 4,
    parameter int APT_WIN    = 512,
    parameter int APT_CUTOFF = 13,
    parameter int STARTUP_N  = 1024
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic                clr_alarm,
    input  logic                in_valid,
    input  logic [SAMPLE_W-1:0] in_data,
    output logic                in_ready,
    output logic                out_valid,
    output logic [SAMPLE_W-1:0] out_data,
    output logic [1:0]          state,
    output logic                rct_fail,
    output logic                apt_fail
);

    localparam int RUN_W   = $clog2(RCT_CUTOFF + 1);
    localparam int MATCH_W = $clog2(APT_CUTOFF + 1);
    localparam int IDX_W   = $clog2(APT_WIN);
    localparam int SU_W    = $clog2(STARTUP_N + 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'b00,
        S_STARTUP = 2'b01,
        S_RUN     = 2'b10,
        S_ALARM   = 2'b11
    } state_t;

    function automatic logic [RUN_W-1:0] sat_run_inc(input logic [RUN_W-1:0] v);
        return (&v) ? v : v + RUN_W'(1);
    endfunction

    function automatic logic [MATCH_W-1:0] sat_match_inc(input logic [MATCH_W-1:0] v);
        return (&v) ? v : v + MATCH_W'(1);
    endfunction

    state_t              r_state;
    state_t              w_state_nxt;
    logic [SAMPLE_W-1:0] r_prev;
    logic [RUN_W-1:0]    r_run;
    logic [SAMPLE_W-1:0] r_ref;
    logic [MATCH_W-1:0]  r_matches;
    logic [IDX_W-1:0]    r_win_idx;
    logic [SU_W-1:0]     r_su_cnt;
    logic                r_out_valid;
    logic [SAMPLE_W-1:0] r_out_data;
    logic                r_rct_fail;
    logic                r_apt_fail;

    logic                w_acc;
    logic [RUN_W-1:0]    w_run_nxt;
    logic [MATCH_W-1:0]  w_match_nxt;
    logic [SU_W-1:0]     w_su_nxt;
    logic                w_su_done;
    logic                w_rct_hit;
    logic                w_apt_hit;
    logic                w_fail;
    logic                w_fwd;

    assign in_ready  = (r_state == S_STARTUP) || (r_state == S_RUN);
    assign state     = r_state;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign rct_fail  = r_rct_fail;
    assign apt_fail  = r_apt_fail;

    // Dropping enable wins over a same-cycle sample, so it is never tested.
    assign w_acc = in_valid && in_ready && enable;

    // A zero run count only occurs before the first sample after IDLE.
    assign w_run_nxt   = (r_run == '0 || in_data != r_prev) ? RUN_W'(1) : sat_run_inc(r_run);
    assign w_match_nxt = (r_win_idx == '0) ? MATCH_W'(1)
                       : (in_data == r_ref) ? sat_match_inc(r_matches) : r_matches;
    assign w_rct_hit   = (w_run_nxt >= RUN_W'(RCT_CUTOFF));
    assign w_apt_hit   = (w_match_nxt >= MATCH_W'(APT_CUTOFF));
    assign w_fail      = w_acc && (w_rct_hit || w_apt_hit);
    assign w_su_nxt    = r_su_cnt + SU_W'(1);
    assign w_su_done   = (w_su_nxt == SU_W'(STARTUP_N));
    assign w_fwd       = w_acc && (r_state == S_RUN) && !w_fail;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (enable) w_state_nxt = S_STARTUP;
            end
            S_STARTUP: begin
                if (!enable)                 w_state_nxt = S_IDLE;
                else if (w_fail)             w_state_nxt = S_ALARM;
                else if (w_acc && w_su_done) w_state_nxt = S_RUN;
            end
            S_RUN: begin
                if (!enable)     w_state_nxt = S_IDLE;
                else if (w_fail) w_state_nxt = S_ALARM;
            end
            S_ALARM: begin
                if (clr_alarm) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Test state is wiped on every entry into IDLE so a restart begins a fresh run and window.
    always_ff @(posedge clk) begin
        if (rst || w_state_nxt == S_IDLE) begin
            r_prev    <= '0;
            r_run     <= '0;
            r_ref     <= '0;
            r_matches <= '0;
            r_win_idx <= '0;
            r_su_cnt  <= '0;
        end else if (w_acc) begin
            r_prev    <= in_data;
            r_run     <= w_run_nxt;
            r_matches <= w_match_nxt;
            if (r_win_idx == '0) r_ref <= in_data;
            r_win_idx <= (r_win_idx == IDX_W'(APT_WIN - 1)) ? '0 : r_win_idx + IDX_W'(1);
            if (r_state == S_STARTUP) r_su_cnt <= w_su_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else begin
            r_out_valid <= w_fwd;
            if (w_fwd) r_out_data <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rct_fail <= 1'b0;
            r_apt_fail <= 1'b0;
        end else if (r_state == S_ALARM && clr_alarm) begin
            r_rct_fail <= 1'b0;
            r_apt_fail <= 1'b0;
        end else if (w_fail) begin
            r_rct_fail <= r_rct_fail | w_rct_hit;
            r_apt_fail <= r_apt_fail | w_apt_hit;
        end
    end

endmodule

// File: tb/tb_health_test_ctrl.sv
// Directed bench for health_test_ctrl: startup, RCT/APT alarms, alarm clear, enable drop and reset.
module tb_health_test_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       clr_alarm;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic [1:0] state;
    logic       rct_fail;
    logic       apt_fail;

    int n_checks = 0;
    int n_pass   = 0;
    int ov_cnt;
    int run_seen;
    logic [1:0] st_pre;

    health_test_ctrl #(
        .SAMPLE_W  (8),
        .RCT_CUTOFF(4),
        .APT_WIN   (512),
        .APT_CUTOFF(13),
        .STARTUP_N (1024)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .enable   (enable),
        .clr_alarm(clr_alarm),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .out_valid(out_valid),
        .out_data (out_data),
        .state    (state),
        .rct_fail (rct_fail),
        .apt_fail (apt_fail)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d);
        in_valid = 1'b1;
        in_data  = d;
        tick();
        in_valid = 1'b0;
        if (out_valid) ov_cnt++;
        if (state == 2'b10) run_seen++;
    endtask

    // 1024 cycling samples 0..255,0..; records the state after accept #1023.
    task automatic startup_seq();
        ov_cnt   = 0;
        run_seen = 0;
        for (int i = 0; i < 1024; i++) begin
            send(8'(i));
            if (i == 1022) st_pre = state;
        end
    endtask

    task automatic clear_and_restart();
        clr_alarm = 1'b1;
        tick();
        clr_alarm = 1'b0;
        tick();
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; clr_alarm = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        ov_cnt = 0; run_seen = 0; st_pre = 2'b00;
        tick();
        tick();
        check("rst_state",     state,     2'b00);
        check("rst_in_ready",  in_ready,  1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data",  out_data,  8'h00);
        check("rst_rct",       rct_fail,  1'b0);
        check("rst_apt",       apt_fail,  1'b0);

        // Startup to RUN
        rst = 1'b0; enable = 1'b1;
        tick();
        check("su_entry",    state,    2'b01);
        check("su_in_ready", in_ready, 1'b1);
        startup_seq();
        check("su_state_1023", st_pre, 2'b01);
        check("su_no_fwd",     ov_cnt, 0);
        check("su_to_run",     state,  2'b10);
        send(8'h10);
        check("fwd_valid", out_valid, 1'b1);
        check("fwd_data",  out_data,  8'h10);
        tick();
        check("fwd_pulse", out_valid, 1'b0);
        check("fwd_hold",  out_data,  8'h10);

        // RCT alarm in RUN
        send(8'hA5); send(8'hA5); send(8'hA5);
        check("rct3_state", state,     2'b10);
        check("rct3_valid", out_valid, 1'b1);
        check("rct3_data",  out_data,  8'hA5);
        send(8'hA5);
        check("rct4_state",    state,     2'b11);
        check("rct4_rct",      rct_fail,  1'b1);
        check("rct4_apt",      apt_fail,  1'b0);
        check("rct4_in_ready", in_ready,  1'b0);
        check("rct4_no_fwd",   out_valid, 1'b0);

        // Alarm clear, counters restart
        clr_alarm = 1'b1;
        tick();
        clr_alarm = 1'b0;
        check("clr_idle", state,    2'b00);
        check("clr_rct",  rct_fail, 1'b0);
        check("clr_apt",  apt_fail, 1'b0);
        tick();
        check("clr_restart", state, 2'b01);
        ov_cnt = 0; run_seen = 0;
        send(8'hA5); send(8'hA5); send(8'hA5);
        check("restart_3eq_state", state,    2'b01);
        check("restart_3eq_rct",   rct_fail, 1'b0);

        // RCT failure on the accept that would complete startup
        for (int k = 3; k < 1020; k++) send(8'(k));
        send(8'h5A); send(8'h5A); send(8'h5A);
        check("last_su_pre", state, 2'b01);
        send(8'h5A);
        check("last_su_alarm", state,    2'b11);
        check("last_su_rct",   rct_fail, 1'b1);
        check("last_su_apt",   apt_fail, 1'b0);
        check("last_su_nofwd", ov_cnt,   0);
        check("last_su_norun", run_seen, 0);

        // APT alarm in RUN
        clear_and_restart();
        startup_seq();
        check("apt_run", state, 2'b10);
        for (int j = 0; j <= 36; j++) begin
            send((j % 3 == 0) ? 8'h3C : 8'(8'h80 + j));
            if (j == 33) begin
                check("apt12_valid", out_valid, 1'b1);
                check("apt12_data",  out_data,  8'h3C);
            end
            if (j == 35) check("apt_pre", state, 2'b10);
        end
        check("apt13_state", state,     2'b11);
        check("apt13_apt",   apt_fail,  1'b1);
        check("apt13_rct",   rct_fail,  1'b0);
        check("apt13_nofwd", out_valid, 1'b0);

        // enable drop in RUN beats a same-cycle sample
        clear_and_restart();
        startup_seq();
        send(8'h21);
        check("en_pre_valid", out_valid, 1'b1);
        enable = 1'b0; in_valid = 1'b1; in_data = 8'h22;
        tick();
        in_valid = 1'b0;
        check("en_idle",     state,     2'b00);
        check("en_no_fwd",   out_valid, 1'b0);
        check("en_data_hold", out_data, 8'h21);

        // rst mid-RUN with a sample in flight
        enable = 1'b1;
        tick();
        startup_seq();
        send(8'h33);
        check("rst_pre_valid", out_valid, 1'b1);
        rst = 1'b1; in_valid = 1'b1; in_data = 8'h44;
        tick();
        in_valid = 1'b0;
        check("mid_rst_state",    state,     2'b00);
        check("mid_rst_valid",    out_valid, 1'b0);
        check("mid_rst_data",     out_data,  8'h00);
        check("mid_rst_in_ready", in_ready,  1'b0);
        check("mid_rst_rct",      rct_fail,  1'b0);
        check("mid_rst_apt",      apt_fail,  1'b0);
        rst = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
